// File: rtl/counter_down_if.sv
// Handshake bundle for counter_down: control inputs and count/borrow outputs.
// The prescale signal exists only when COUNTER_DOWN_PRESCALE_EN is defined.
interface counter_down_if #(
   parameter int DW = 16,
   parameter int PW = 8
);
   logic          en;
   logic          start;
   logic          stop;
   logic          periodic;
   logic [DW-1:0] reload;
`ifdef COUNTER_DOWN_PRESCALE_EN
   logic [PW-1:0] prescale;
`endif
   logic [DW-1:0] cnt;
   logic          bo;
   logic          busy;

   modport master (
`ifdef COUNTER_DOWN_PRESCALE_EN
      output prescale,
`endif
      output en,
      output start,
      output stop,
      output periodic,
      output reload,
      input  cnt,
      input  bo,
      input  busy
   );

   modport slave (
`ifdef COUNTER_DOWN_PRESCALE_EN
      input  prescale,
`endif
      input  en,
      input  start,
      input  stop,
      input  periodic,
      input  reload,
      output cnt,
      output bo,
      output busy
   );
endinterface

// File: rtl/counter_down.sv
// Loadable down counter with one-shot/periodic modes and a borrow pulse.
// Define COUNTER_DOWN_PRESCALE_EN to compile in the tick prescaler.
module counter_down #(
   parameter int DW = 16,
   parameter int PW = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   counter_down_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [DW-1:0] cnt_q, cnt_nx;
   logic          tick;
   logic          run;
   logic          zero;
   logic          do_load;
   logic          do_stop;
   logic          do_wrap;
   logic          do_dec;
   logic          bo_c;

   assign run  = (state == RUN);
   assign zero = (cnt_q == '0);

`ifdef COUNTER_DOWN_PRESCALE_EN
   logic [PW-1:0] psc_q, psc_nx;

   assign tick = bus.en && (psc_q == bus.prescale);

   always_comb begin
      psc_nx = psc_q;
      if (bus.start || !run)
         psc_nx = '0;
      else if (bus.en)
         psc_nx = (psc_q == bus.prescale) ? '0 : psc_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         psc_q <= '0;
      else
         psc_q <= psc_nx;
   end
`else
   assign tick = bus.en;
`endif

   // Decoded actions are mutually exclusive: start > stop > tick.
   assign do_load = bus.start;
   assign do_stop = run && bus.stop && !bus.start;
   assign do_wrap = run && tick && zero && !bus.start && !bus.stop;
   assign do_dec  = run && tick && !zero && !bus.start && !bus.stop;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt_q;
      bo_c     = 1'b0;
      unique case (1'b1)
         do_load: begin
            state_nx = RUN;
            cnt_nx   = bus.reload;
         end
         do_stop: begin
            state_nx = IDLE;
         end
         do_wrap: begin
            bo_c = 1'b1;
            if (bus.periodic)
               cnt_nx = bus.reload;
            else
               state_nx = IDLE;
         end
         do_dec: begin
            cnt_nx = cnt_q - 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt_q <= '0;
      end else begin
         state <= state_nx;
         cnt_q <= cnt_nx;
      end
   end

   assign bus.cnt  = cnt_q;
   assign bus.bo   = bo_c;
   assign bus.busy = run;

endmodule

// File: tb/tb_counter_down.sv
// Table-driven scoreboard bench for counter_down.
// Prescaler sequence runs only with COUNTER_DOWN_PRESCALE_EN defined.
module tb_counter_down;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   counter_down_if #(.DW(16), .PW(8)) bus ();

   counter_down #(.DW(16), .PW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        en;
      logic        start;
      logic        stop;
      logic        periodic;
      logic [15:0] reload;
      logic [15:0] cnt;
      logic        bo;
      logic        busy;
   } vec_t;

   typedef struct {
      logic [15:0] cnt;
      logic        bo;
      logic        busy;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic cmp(input string name, input logic [15:0] act,
                      input logic [15:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req,
                  $time);
      end
   endtask

   task automatic addv(input logic en, input logic start, input logic stop,
                       input logic per, input logic [15:0] rl,
                       input logic [15:0] c, input logic b,
                       input logic bz);
      vec_t v;
      v.en = en; v.start = start; v.stop = stop; v.periodic = per;
      v.reload = rl; v.cnt = c; v.bo = b; v.busy = bz;
      vecs.push_back(v);
   endtask

   // Drive one cycle; outputs checked on the falling edge.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      bus.en       = v.en;
      bus.start    = v.start;
      bus.stop     = v.stop;
      bus.periodic = v.periodic;
      bus.reload   = v.reload;
      sb.push_back('{cnt: v.cnt, bo: v.bo, busy: v.busy});
      @(negedge clk);
      if (sb.size() == 0) begin
         cmp({tag, "_sb_empty"}, 16'd1, 16'd0);
      end else begin
         e = sb.pop_front();
         cmp({tag, "_cnt"}, bus.cnt, e.cnt);
         cmp({tag, "_bo"}, {15'd0, bus.bo}, {15'd0, e.bo});
         cmp({tag, "_busy"}, {15'd0, bus.busy}, {15'd0, e.busy});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic en, input logic start, input logic stop,
                       input logic per, input logic [15:0] rl,
                       input logic [15:0] c, input logic b,
                       input logic bz, input string tag);
      vec_t v;
      v.en = en; v.start = start; v.stop = stop; v.periodic = per;
      v.reload = rl; v.cnt = c; v.bo = b; v.busy = bz;
      apply(v, tag);
   endtask

   initial begin
      // en st sp per reload  cnt bo busy
      addv(0, 0, 0, 0, 16'd3, 16'd0, 0, 0);
      // one-shot, reload 3
      addv(1, 1, 0, 0, 16'd3, 16'd0, 0, 0);
      addv(1, 0, 0, 0, 16'd3, 16'd3, 0, 1);
      addv(1, 0, 0, 0, 16'd3, 16'd2, 0, 1);
      addv(1, 0, 0, 0, 16'd3, 16'd1, 0, 1);
      addv(1, 0, 0, 0, 16'd3, 16'd0, 1, 1);
      addv(1, 0, 0, 0, 16'd3, 16'd0, 0, 0);
      addv(1, 0, 0, 0, 16'd3, 16'd0, 0, 0);
      // periodic, reload 2
      addv(1, 1, 0, 1, 16'd2, 16'd0, 0, 0);
      for (int i = 0; i < 9; i++)
         addv(1, 0, 0, 1, 16'd2, 16'(2 - (i % 3)), (i % 3) == 2, 1);
      addv(1, 0, 1, 1, 16'd2, 16'd2, 0, 1);
      addv(1, 0, 0, 1, 16'd2, 16'd2, 0, 0);
      // stop at 5, stop in idle, start+stop collisions
      addv(0, 1, 0, 0, 16'd6, 16'd2, 0, 0);
      addv(1, 0, 0, 0, 16'd6, 16'd6, 0, 1);
      addv(1, 0, 1, 0, 16'd6, 16'd5, 0, 1);
      addv(1, 0, 0, 0, 16'd6, 16'd5, 0, 0);
      addv(0, 0, 1, 0, 16'd6, 16'd5, 0, 0);
      addv(1, 1, 1, 0, 16'd4, 16'd5, 0, 0);
      addv(0, 0, 0, 0, 16'd4, 16'd4, 0, 1);
      addv(0, 0, 0, 0, 16'd9, 16'd4, 0, 1);
      addv(1, 1, 1, 0, 16'd7, 16'd4, 0, 1);
      addv(0, 0, 0, 0, 16'd7, 16'd7, 0, 1);
      // zero reload, periodic, gapped enable
      addv(0, 1, 0, 1, 16'd0, 16'd7, 0, 1);
      addv(1, 0, 0, 1, 16'd0, 16'd0, 1, 1);
      addv(0, 0, 0, 1, 16'd0, 16'd0, 0, 1);
      addv(1, 0, 0, 1, 16'd0, 16'd0, 1, 1);
      addv(0, 0, 0, 1, 16'd0, 16'd0, 0, 1);
      addv(1, 0, 0, 1, 16'd0, 16'd0, 1, 1);
      addv(1, 1, 0, 1, 16'd0, 16'd0, 0, 1);
      addv(0, 0, 1, 1, 16'd0, 16'd0, 0, 1);

      bus.en = 1'b1; bus.start = 1'b1; bus.stop = 1'b0;
      bus.periodic = 1'b1; bus.reload = 16'd5;
`ifdef COUNTER_DOWN_PRESCALE_EN
      bus.prescale = 8'd0;
`endif
      // Reset held with activity on the inputs
      @(negedge clk);
      cmp("rst_cnt", bus.cnt, 16'd0);
      cmp("rst_bo", {15'd0, bus.bo}, 16'd0);
      cmp("rst_busy", {15'd0, bus.busy}, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], $sformatf("v%0d", i));

      // Reset mid-count at cnt=7
      step(1, 1, 0, 0, 16'd9, 16'd0, 0, 0, "mr0");
      step(1, 0, 0, 0, 16'd9, 16'd9, 0, 1, "mr1");
      step(1, 0, 0, 0, 16'd9, 16'd8, 0, 1, "mr2");
      cmp("mr_pre_cnt", bus.cnt, 16'd7);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("mr_cnt", bus.cnt, 16'd0);
      cmp("mr_bo", {15'd0, bus.bo}, 16'd0);
      cmp("mr_busy", {15'd0, bus.busy}, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         step(1, 0, 0, 0, 16'd9, 16'd0, 0, 0, $sformatf("mq%0d", i));
      step(1, 1, 0, 0, 16'd1, 16'd0, 0, 0, "ms0");
      step(1, 0, 0, 0, 16'd1, 16'd1, 0, 1, "ms1");
      step(1, 0, 0, 0, 16'd1, 16'd0, 1, 1, "ms2");
      step(1, 0, 0, 0, 16'd1, 16'd0, 0, 0, "ms3");

`ifdef COUNTER_DOWN_PRESCALE_EN
      // prescale=3, reload=1: tick every 4 cycles, bo every 8
      bus.prescale = 8'd3;
      step(1, 1, 0, 1, 16'd1, 16'd0, 0, 0, "ps_st");
      for (int k = 0; k < 24; k++)
         step(1, 0, 0, 1, 16'd1, ((k / 4) % 2 == 0) ? 16'd1 : 16'd0,
              (k % 8) == 7, 1, $sformatf("ps%0d", k));
      bus.prescale = 8'd0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
